// File: rtl/dog_pkg.sv
// Shared definitions for the DoG RAM responder.
// Defaults, FSM state encodings and read-latency bounds.
package dog_pkg;

    localparam int ADDR_W_DEF = 16;
    localparam int DATA_W_DEF = 8;
    localparam int CNT_W_DEF  = 16;

    localparam int RD_LAT_MIN = 1;
    localparam int RD_LAT_MAX = 4;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/dog_ram_rsp_if.sv
// Request/response bundle between a DoG RAM requester and responder.
// master = requester side, slave = responder (bank) side.
interface dog_ram_rsp_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
);

    logic              rd_valid_in;
    logic [ADDR_W-1:0] rd_addr_in;
    logic              wr_valid_in;
    logic [ADDR_W-1:0] wr_addr_in;
    logic [DATA_W-1:0] wr_data_in;
    logic              rd_valid_out;
    logic [DATA_W-1:0] rd_data_out;
    logic              ready;
    logic              err_oob;
    logic [CNT_W-1:0]  rd_cnt;
    logic [CNT_W-1:0]  wr_cnt;

    modport master (
        output rd_valid_in, rd_addr_in,
        output wr_valid_in, wr_addr_in, wr_data_in,
        input  rd_valid_out, rd_data_out,
        input  ready, err_oob, rd_cnt, wr_cnt
    );

    modport slave (
        input  rd_valid_in, rd_addr_in,
        input  wr_valid_in, wr_addr_in, wr_data_in,
        output rd_valid_out, rd_data_out,
        output ready, err_oob, rd_cnt, wr_cnt
    );

endinterface

// File: rtl/dog_ram_rd_pipe.sv
// Fixed-latency read return pipeline (RD_LAT stages).
// Data registers only load with valid, so the output holds its last value.
module dog_ram_rd_pipe
    import dog_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int RD_LAT = RD_LAT_MIN
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data
);

    logic [RD_LAT-1:0] v;
    logic [DATA_W-1:0] d [RD_LAT];

    // Shift valid every cycle; shift data only behind a valid bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v <= '0;
            for (int i = 0; i < RD_LAT; i++) d[i] <= '0;
        end else begin
            v[0] <= in_valid;
            if (in_valid) d[0] <= in_data;
            for (int i = 1; i < RD_LAT; i++) begin
                v[i] <= v[i-1];
                if (v[i-1]) d[i] <= d[i-1];
            end
        end
    end

    assign out_valid = v[RD_LAT-1];
    assign out_data  = d[RD_LAT-1];

endmodule

// File: rtl/dog_ram_rsp.sv
// DoG RAM responder: one image bank with init sweep, stats and errors.
// Define DOG_RAM_WR_BYPASS_EN for write-first same-address behaviour.
module dog_ram_rsp
    import dog_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int DEPTH    = 4096,
    parameter int RD_LAT   = 1,
    parameter int INIT_VAL = 0,
    parameter int CNT_W    = CNT_W_DEF
) (
    input logic         clk,
    input logic         rst_n,
    dog_ram_rsp_if.slave bus
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0]   LIMIT  = (ADDR_W+1)'(DEPTH);
    localparam logic [PTR_W-1:0]  LAST   = PTR_W'(DEPTH - 1);
    localparam logic [DATA_W-1:0] INIT_D = DATA_W'(INIT_VAL);
    localparam logic [CNT_W-1:0]  CMAX   = '1;

    state_t            state;
    logic [PTR_W-1:0]  ptr;
    logic              rdy;
    logic [DATA_W-1:0] mem [DEPTH];

    logic              run;
    logic              rd_in, wr_in;
    logic              rd_ok, wr_ok;
    logic              rd_bad, wr_bad, early;
    logic [PTR_W-1:0]  rd_idx, wr_idx;
    logic [DATA_W-1:0] rd_data;

    assign run    = (state == ST_RUN);
    assign rd_in  = ({1'b0, bus.rd_addr_in} < LIMIT);
    assign wr_in  = ({1'b0, bus.wr_addr_in} < LIMIT);
    assign rd_ok  = run & bus.rd_valid_in & rd_in;
    assign wr_ok  = run & bus.wr_valid_in & wr_in;
    assign rd_bad = run & bus.rd_valid_in & ~rd_in;
    assign wr_bad = run & bus.wr_valid_in & ~wr_in;
    assign early  = ~run & (bus.rd_valid_in | bus.wr_valid_in);
    assign rd_idx = bus.rd_addr_in[PTR_W-1:0];
    assign wr_idx = bus.wr_addr_in[PTR_W-1:0];

    // Read data entering the pipe; out-of-range reads return zero.
    always_comb begin
        rd_data = '0;
        if (rd_ok) rd_data = mem[rd_idx];
`ifdef DOG_RAM_WR_BYPASS_EN
        if (rd_ok && wr_ok && (bus.wr_addr_in == bus.rd_addr_in))
            rd_data = bus.wr_data_in;
`endif
    end

    // Bank storage: init sweep owns the port until RUN.
    always_ff @(posedge clk) begin
        if (state == ST_INIT) mem[ptr] <= INIT_D;
        else if (wr_ok) mem[wr_idx] <= bus.wr_data_in;
    end

    // INIT -> RUN sequencer with registered ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_INIT;
            ptr   <= '0;
            rdy   <= 1'b0;
        end else begin
            unique case (state)
                ST_INIT: begin
                    ptr <= ptr + 1'b1;
                    if (ptr == LAST) begin
                        state <= ST_RUN;
                        rdy   <= 1'b1;
                    end
                end
                ST_RUN: rdy <= 1'b1;
            endcase
        end
    end

    // Saturating request counters and sticky error flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.rd_cnt  <= '0;
            bus.wr_cnt  <= '0;
            bus.err_oob <= 1'b0;
        end else begin
            if (run && bus.rd_valid_in && bus.rd_cnt != CMAX)
                bus.rd_cnt <= bus.rd_cnt + 1'b1;
            if (wr_ok && bus.wr_cnt != CMAX)
                bus.wr_cnt <= bus.wr_cnt + 1'b1;
            if (rd_bad || wr_bad || early)
                bus.err_oob <= 1'b1;
        end
    end

    assign bus.ready = rdy;

    dog_ram_rd_pipe #(
        .DATA_W (DATA_W),
        .RD_LAT (RD_LAT)
    ) u_pipe (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (run & bus.rd_valid_in),
        .in_data   (rd_data),
        .out_valid (bus.rd_valid_out),
        .out_data  (bus.rd_data_out)
    );

endmodule
